// File: rtl/alu_op_pkg.sv
// Shared constants for the ALU request sequencer: funct codes, ALU select
// codes, FSM state encoding and the decoder result record.
`timescale 1ns/1ps
package alu_op_pkg;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_ANDN = 6'h34;
  localparam logic [5:0] FUNCT_ORN  = 6'h35;

  localparam logic [2:0] F_AND  = 3'b000;
  localparam logic [2:0] F_OR   = 3'b001;
  localparam logic [2:0] F_ADD  = 3'b010;
  localparam logic [2:0] F_ANDN = 3'b100;
  localparam logic [2:0] F_ORN  = 3'b101;
  localparam logic [2:0] F_SUB  = 3'b110;
  localparam logic [2:0] F_SLT  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef struct packed {
    logic       legal;
    logic [2:0] f;
    logic       is_add;
    logic       is_slt;
  } funct_dec_t;

endpackage

// File: rtl/alu_funct_decoder.sv
// Combinational funct -> ALU select decode; unknown funct codes come back
// with legal cleared and a zero select.
`timescale 1ns/1ps
module alu_funct_decoder
  import alu_op_pkg::*;
(
  input  logic [5:0] funct,
  output funct_dec_t dec
);

  // funct code lookup
  always_comb begin
    dec = '{legal: 1'b0, f: 3'b000, is_add: 1'b0, is_slt: 1'b0};
    case (funct)
      FUNCT_ADD:  dec = '{legal: 1'b1, f: F_ADD,  is_add: 1'b1, is_slt: 1'b0};
      FUNCT_SUB:  dec = '{legal: 1'b1, f: F_SUB,  is_add: 1'b0, is_slt: 1'b0};
      FUNCT_AND:  dec = '{legal: 1'b1, f: F_AND,  is_add: 1'b0, is_slt: 1'b0};
      FUNCT_OR:   dec = '{legal: 1'b1, f: F_OR,   is_add: 1'b0, is_slt: 1'b0};
      FUNCT_SLT:  dec = '{legal: 1'b1, f: F_SLT,  is_add: 1'b0, is_slt: 1'b1};
      FUNCT_ANDN: dec = '{legal: 1'b1, f: F_ANDN, is_add: 1'b0, is_slt: 1'b0};
      FUNCT_ORN:  dec = '{legal: 1'b1, f: F_ORN,  is_add: 1'b0, is_slt: 1'b0};
      default:    dec = '{legal: 1'b0, f: 3'b000, is_add: 1'b0, is_slt: 1'b0};
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response controller for an external combinational ALU: one op in
// flight, registered ALU drive, normalised result and saturating counters.
`timescale 1ns/1ps
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  output logic [2:0]       alu_f,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [N-1:0]     alu_y,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_y,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]  state_r;
  logic        is_add_r;
  logic        is_slt_r;
  funct_dec_t  dec_s;

  alu_funct_decoder u_decoder (
    .funct (req_funct),
    .dec   (dec_s)
  );

  // Sequencer FSM with operand, response and counter registers.
  // DONE spends its first cycle raising rsp_valid, so responses appear two
  // edges after a legal accept and one edge after an illegal one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      is_add_r  <= 1'b0;
      is_slt_r  <= 1'b0;
      req_ready <= 1'b1;
      alu_f     <= 3'b000;
      alu_a     <= {N{1'b0}};
      alu_b     <= {N{1'b0}};
      rsp_valid <= 1'b0;
      rsp_y     <= {N{1'b0}};
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
      op_count  <= {CNT_W{1'b0}};
      err_count <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (dec_s.legal) begin
              alu_f    <= dec_s.f;
              alu_a    <= req_a;
              alu_b    <= req_b;
              is_add_r <= dec_s.is_add;
              is_slt_r <= dec_s.is_slt;
              state_r  <= ST_EXEC;
            end else begin
              // illegal ops never touch the ALU drive registers
              rsp_y     <= {N{1'b0}};
              rsp_zero  <= 1'b1;
              rsp_carry <= 1'b0;
              rsp_err   <= 1'b1;
              state_r   <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          if (is_slt_r) begin
            rsp_y    <= {{(N-1){1'b0}}, alu_y[0]};
            rsp_zero <= ~alu_y[0];
          end else begin
            rsp_y    <= alu_y;
            rsp_zero <= alu_zero;
          end
          rsp_carry <= is_add_r & alu_overflow;
          rsp_err   <= 1'b0;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= ST_IDLE;
            if (rsp_err) begin
              if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
            end else begin
              if (op_count != CNT_MAX) op_count <= op_count + CNT_ONE;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer (N=8, 3-bit counters) with a
// behavioural n_bit_alu model attached to the ALU ports.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int N     = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_funct;
  logic [N-1:0]     req_a;
  logic [N-1:0]     req_b;
  logic [2:0]       alu_f;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [N-1:0]     alu_y;
  logic             alu_zero;
  logic             alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_y;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_err;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct    (req_funct),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_f        (alu_f),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_y        (alu_y),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_zero     (rsp_zero),
    .rsp_carry    (rsp_carry),
    .rsp_err      (rsp_err),
    .op_count     (op_count),
    .err_count    (err_count)
  );

  // ALU model: F[2] inverts B and supplies carry-in; SLT leaves junk in the
  // upper bits so the sequencer's normalisation is actually exercised.
  logic [N-1:0] b_eff;
  logic [N:0]   sum9;
  assign b_eff = alu_f[2] ? ~alu_b : alu_b;
  assign sum9  = {1'b0, alu_a} + {1'b0, b_eff} + {{N{1'b0}}, alu_f[2]};
  always_comb begin
    case (alu_f[1:0])
      2'b00:   alu_y = alu_a & b_eff;
      2'b01:   alu_y = alu_a | b_eff;
      2'b10:   alu_y = sum9[N-1:0];
      default: alu_y = {sum9[N-1:1], sum9[N-1]};
    endcase
  end
  assign alu_zero     = (alu_y == {N{1'b0}});
  assign alu_overflow = sum9[N];

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic send(input logic [5:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    int cyc;
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL send_timeout req_ready got %b exp 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 10) begin @(negedge clk); cyc++; end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if ({alu_f, alu_a, alu_b} !== 19'd0) begin errors++; $display("FAIL reset_alu got %h exp 0", {alu_f, alu_a, alu_b}); end
    checks++; if ({rsp_y, rsp_zero, rsp_carry, rsp_err} !== 11'd0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {rsp_y, rsp_zero, rsp_carry, rsp_err}); end
    checks++; if ({op_count, err_count} !== 6'd0) begin errors++; $display("FAIL reset_counts got %h exp 0", {op_count, err_count}); end
  endtask

  // Legal op: checks latency, result, flags, ALU select and op counter.
  task automatic run_op(input string name, input logic [5:0] f, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [2:0] exp_f, input logic [N-1:0] exp_y,
                        input logic exp_z, input logic exp_c, input logic [CNT_W-1:0] exp_cnt);
    int cyc;
    send(f, a, b);
    wait_rsp(cyc);
    checks++; if (cyc != 2) begin errors++; $display("FAIL %s_latency got %0d exp 2", name, cyc); end
    checks++; if (alu_f !== exp_f) begin errors++; $display("FAIL %s_alu_f got %b exp %b", name, alu_f, exp_f); end
    checks++; if (rsp_y !== exp_y) begin errors++; $display("FAIL %s_y got %h exp %h", name, rsp_y, exp_y); end
    checks++; if ({rsp_zero, rsp_carry, rsp_err} !== {exp_z, exp_c, 1'b0}) begin
      errors++; $display("FAIL %s_flags zce got %b exp %b", name, {rsp_zero, rsp_carry, rsp_err}, {exp_z, exp_c, 1'b0}); end
    take_rsp();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL %s_release vr got %b exp 01", name, {rsp_valid, req_ready}); end
    checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL %s_op_count got %0d exp %0d", name, op_count, exp_cnt); end
  endtask

  task automatic test_ops();
    run_op("add",  6'h20, 8'h07, 8'h05, 3'b010, 8'h0C, 1'b0, 1'b0, 3'd1);
    run_op("addc", 6'h20, 8'hFF, 8'h01, 3'b010, 8'h00, 1'b1, 1'b1, 3'd2);
    run_op("sub",  6'h22, 8'h05, 8'h05, 3'b110, 8'h00, 1'b1, 1'b0, 3'd3);
    run_op("slt1", 6'h2A, 8'h03, 8'h05, 3'b111, 8'h01, 1'b0, 1'b0, 3'd4);
    run_op("slt0", 6'h2A, 8'h05, 8'h03, 3'b111, 8'h00, 1'b1, 1'b0, 3'd5);
    run_op("andn", 6'h34, 8'hF0, 8'h30, 3'b100, 8'hC0, 1'b0, 1'b0, 3'd6);
    run_op("orn",  6'h35, 8'h00, 8'h0F, 3'b101, 8'hF0, 1'b0, 1'b0, 3'd7);
  endtask

  task automatic test_saturate();
    run_op("sat", 6'h20, 8'h0A, 8'h14, 3'b010, 8'h1E, 1'b0, 1'b0, 3'd7);
  endtask

  task automatic test_illegal();
    int cyc;
    send(6'h3F, 8'h55, 8'hAA);
    wait_rsp(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL ill_latency got %0d exp 1", cyc); end
    checks++; if ({rsp_err, rsp_y, rsp_zero, rsp_carry} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ill_rsp got %h exp %h", {rsp_err, rsp_y, rsp_zero, rsp_carry}, {1'b1, 8'h00, 1'b1, 1'b0}); end
    checks++; if ({alu_f, alu_a, alu_b} !== {3'b010, 8'h0A, 8'h14}) begin
      errors++; $display("FAIL ill_alu_kept got %h exp %h", {alu_f, alu_a, alu_b}, {3'b010, 8'h0A, 8'h14}); end
    take_rsp();
    checks++; if ({err_count, op_count} !== {3'd1, 3'd7}) begin
      errors++; $display("FAIL ill_counts err/op got %0d/%0d exp 1/7", err_count, op_count); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    send(6'h25, 8'h01, 8'h02);
    wait_rsp(cyc);
    req_valid = 1'b1; req_funct = 6'h22; req_a = 8'h09; req_b = 8'h04;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_y, req_ready} !== {1'b1, 8'h03, 1'b0}) begin
        errors++; $display("FAIL stall_%0d vyr got %h exp %h", i, {rsp_valid, rsp_y, req_ready}, {1'b1, 8'h03, 1'b0}); end
      checks++; if (alu_a !== 8'h01) begin errors++; $display("FAIL stall_%0d_alu_a got %h exp 01", i, alu_a); end
    end
    take_rsp();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL b2b_release vr got %b exp 01", {rsp_valid, req_ready}); end
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(cyc);
    checks++; if (cyc != 2) begin errors++; $display("FAIL b2b_latency got %0d exp 2", cyc); end
    checks++; if ({rsp_y, alu_f} !== {8'h05, 3'b110}) begin errors++; $display("FAIL b2b_second got %h exp %h", {rsp_y, alu_f}, {8'h05, 3'b110}); end
    take_rsp();
  endtask

  task automatic test_reset_mid_exec();
    send(6'h20, 8'h02, 8'h02);
    rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, alu_a, op_count, err_count} !== {1'b1, 1'b0, 8'h00, 3'd0, 3'd0}) begin
      errors++; $display("FAIL rst_exec got %h exp %h", {req_ready, rsp_valid, alu_a, op_count, err_count}, {1'b1, 1'b0, 8'h00, 3'd0, 3'd0}); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, req_ready, op_count, err_count} !== {1'b0, 1'b1, 3'd0, 3'd0}) begin
      errors++; $display("FAIL rst_exec_after got %h exp %h", {rsp_valid, req_ready, op_count, err_count}, {1'b0, 1'b1, 3'd0, 3'd0}); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_funct = 6'h00; req_a = 8'h00; req_b = 8'h00; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_ops();
    test_saturate();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
